// File: rtl/md_unit.sv
// Multiply/divide unit for the E stage: one mult/div in flight at a time,
// with a fixed per-class latency and results committed to HI/LO on the final edge.
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [7:0]       MULT_N = 8'(MULT_CYCLES);
  localparam logic [7:0]       DIV_N  = 8'(DIV_CYCLES);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

  state_t           state, state_next;
  logic [7:0]       count, count_next;
  logic [WIDTH-1:0] a_q, b_q;
  logic [1:0]       op_q;
  logic             latch, finish, write_hi, write_lo;

  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic               div_zero;
  logic [WIDTH-1:0]   mag_a, mag_b, divisor_s, divisor_u;
  logic [WIDTH-1:0]   q_mag, r_mag, q_s, r_s, q_u, r_u;
  logic [WIDTH-1:0]   res_hi, res_lo;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // cancel squashes both a pending start and an in-flight op, including on its final edge
  always_comb begin
    state_next = state;
    count_next = count;
    latch      = 1'b0;
    finish     = 1'b0;
    write_hi   = 1'b0;
    write_lo   = 1'b0;
    case (state)
      IDLE: begin
        if (start && !cancel) begin
          if (!op[2]) begin
            latch      = 1'b1;
            count_next = op[1] ? DIV_N : MULT_N;
            state_next = RUN;
          end else if (!op[1]) begin
            write_hi = !op[0];
            write_lo = op[0];
          end
        end
      end
      RUN: begin
        if (cancel) begin
          state_next = IDLE;
          count_next = '0;
        end else if (count == 8'd1) begin
          finish     = 1'b1;
          state_next = IDLE;
          count_next = '0;
        end else begin
          count_next = count - 8'd1;
        end
      end
    endcase
  end

  // Signed division works on magnitudes, then restores the signs; the
  // most-negative / -1 case falls out as most-negative with zero remainder.
  always_comb begin
    prod_s    = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
    prod_u    = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    div_zero  = (b_q == '0);
    mag_a     = a_q[WIDTH-1] ? -a_q : a_q;
    mag_b     = b_q[WIDTH-1] ? -b_q : b_q;
    divisor_s = div_zero ? ONE : mag_b;
    divisor_u = div_zero ? ONE : b_q;
    q_mag     = mag_a / divisor_s;
    r_mag     = mag_a % divisor_s;
    q_s       = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -q_mag : q_mag;
    r_s       = a_q[WIDTH-1] ? -r_mag : r_mag;
    q_u       = a_q / divisor_u;
    r_u       = a_q % divisor_u;
    case (op_q)
      2'b00:   {res_hi, res_lo} = prod_s;
      2'b01:   {res_hi, res_lo} = prod_u;
      2'b10:   {res_hi, res_lo} = {r_s, q_s};
      default: {res_hi, res_lo} = {r_u, q_u};
    endcase
    if (op_q[1] && div_zero) begin
      res_hi = a_q;
      res_lo = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
      hi   <= '0;
      lo   <= '0;
    end else begin
      if (latch) begin
        a_q  <= a;
        b_q  <= b;
        op_q <= op[1:0];
      end
      if (finish) begin
        hi <= res_hi;
        lo <= res_lo;
      end
      if (write_hi) hi <= a;
      if (write_lo) lo <= a;
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed corner cases plus randomized ops against a
// 64-bit arithmetic reference; a second instance covers single-cycle latency.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        cancel = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, busy1;
  logic [31:0] hi, lo, hi1, lo1;
  int          total = 0;
  int          bad = 0;

  md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .hi(hi), .lo(lo)
  );

  md_unit #(.WIDTH(32), .MULT_CYCLES(1), .DIV_CYCLES(1)) dut_fast (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy1), .hi(hi1), .lo(lo1)
  );

  always #5 clk = ~clk;

  // Reference: full-width 64-bit arithmetic; returns {hi, lo}
  function automatic logic [63:0] model(input logic [2:0] f_op, input logic [31:0] x,
                                        input logic [31:0] y);
    longint          sx, sy, sq, sr;
    longint unsigned ux, uy, uq, ur;
    logic [63:0]     r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    r  = '0;
    case (f_op)
      3'd0: r = sx * sy;
      3'd1: r = ux * uy;
      3'd2, 3'd3: begin
        if (y == 32'd0) r = {x, 32'hFFFFFFFF};
        else if (f_op == 3'd2) begin
          sq = sx / sy;
          sr = sx % sy;
          r  = {sr[31:0], sq[31:0]};
        end else begin
          uq = ux / uy;
          ur = ux % uy;
          r  = {ur[31:0], uq[31:0]};
        end
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] f_op, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = f_op;
    a     = x;
    b     = y;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 400) begin
      cycles++;
      tick();
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    total++; if (hi !== 32'd0) begin bad++; $display("[TB] FAIL reset_hi: got %h want 0", hi); end
    total++; if (lo !== 32'd0) begin bad++; $display("[TB] FAIL reset_lo: got %h want 0", lo); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_mult();
    int n;
    issue(3'd0, 32'hFFFFFFFE, 32'd3);
    wait_idle(n);
    total++; if (n != 5) begin bad++; $display("[TB] FAIL mult_busy_cycles: got %0d want 5", n); end
    total++; if (hi !== 32'hFFFFFFFF) begin bad++; $display("[TB] FAIL mult_hi: got %h want ffffffff", hi); end
    total++; if (lo !== 32'hFFFFFFFA) begin bad++; $display("[TB] FAIL mult_lo: got %h want fffffffa", lo); end
    issue(3'd1, 32'hFFFFFFFF, 32'd2);
    wait_idle(n);
    total++; if (n != 5) begin bad++; $display("[TB] FAIL multu_busy_cycles: got %0d want 5", n); end
    total++; if (hi !== 32'h1) begin bad++; $display("[TB] FAIL multu_hi: got %h want 00000001", hi); end
    total++; if (lo !== 32'hFFFFFFFE) begin bad++; $display("[TB] FAIL multu_lo: got %h want fffffffe", lo); end
  endtask

  task automatic test_div();
    int n;
    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    wait_idle(n);
    total++; if (n != 10) begin bad++; $display("[TB] FAIL div_busy_cycles: got %0d want 10", n); end
    total++; if (lo !== 32'hFFFFFFFD) begin bad++; $display("[TB] FAIL div_lo: got %h want fffffffd", lo); end
    total++; if (hi !== 32'hFFFFFFFF) begin bad++; $display("[TB] FAIL div_hi: got %h want ffffffff", hi); end
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n);
    total++; if (lo !== 32'h80000000) begin bad++; $display("[TB] FAIL div_ovf_lo: got %h want 80000000", lo); end
    total++; if (hi !== 32'h0) begin bad++; $display("[TB] FAIL div_ovf_hi: got %h want 0", hi); end
    issue(3'd3, 32'd9, 32'd0);
    wait_idle(n);
    total++; if (n != 10) begin bad++; $display("[TB] FAIL divu_zero_cycles: got %0d want 10", n); end
    total++; if (lo !== 32'hFFFFFFFF) begin bad++; $display("[TB] FAIL divu_zero_lo: got %h want ffffffff", lo); end
    total++; if (hi !== 32'd9) begin bad++; $display("[TB] FAIL divu_zero_hi: got %h want 9", hi); end
  endtask

  task automatic test_move();
    issue(3'd4, 32'h1234, 32'd0);
    total++; if (hi !== 32'h1234) begin bad++; $display("[TB] FAIL mthi_hi: got %h want 1234", hi); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL mthi_busy: got %b want 0", busy); end
    issue(3'd5, 32'hCAFE0001, 32'd0);
    total++; if (lo !== 32'hCAFE0001) begin bad++; $display("[TB] FAIL mtlo_lo: got %h want cafe0001", lo); end
    total++; if (hi !== 32'h1234) begin bad++; $display("[TB] FAIL mtlo_keeps_hi: got %h want 1234", hi); end
  endtask

  task automatic test_start_while_busy();
    int          n;
    logic [63:0] exp;
    exp = model(3'd0, 32'h00010000, 32'h00030001);
    issue(3'd0, 32'h00010000, 32'h00030001);
    issue(3'd5, 32'hDEADBEEF, 32'd0);
    issue(3'd0, 32'd1, 32'd1);
    wait_idle(n);
    total++; if (n != 3) begin bad++; $display("[TB] FAIL busy_ignore_cycles: got %0d want 3", n); end
    total++; if ({hi, lo} !== exp) begin bad++; $display("[TB] FAIL busy_ignore_result: got %h want %h", {hi, lo}, exp); end
  endtask

  task automatic test_cancel();
    issue(3'd4, 32'hAAAA5555, 32'd0);
    issue(3'd5, 32'h5555AAAA, 32'd0);
    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    tick();
    tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL cancel_busy: got %b want 0", busy); end
    repeat (8) tick();
    total++; if (hi !== 32'hAAAA5555) begin bad++; $display("[TB] FAIL cancel_hi: got %h want aaaa5555", hi); end
    total++; if (lo !== 32'h5555AAAA) begin bad++; $display("[TB] FAIL cancel_lo: got %h want 5555aaaa", lo); end
    cancel = 1'b1;
    issue(3'd4, 32'h0BAD0BAD, 32'd0);
    issue(3'd0, 32'd3, 32'd3);
    cancel = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL cancel_start_busy: got %b want 0", busy); end
    total++; if (hi !== 32'hAAAA5555) begin bad++; $display("[TB] FAIL cancel_start_hi: got %h want aaaa5555", hi); end
  endtask

  task automatic test_cancel_on_completion();
    issue(3'd0, 32'd7, 32'd9);
    repeat (4) tick();
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL cancel_last_pre_busy: got %b want 1", busy); end
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL cancel_last_busy: got %b want 0", busy); end
    total++; if ({hi, lo} !== {32'hAAAA5555, 32'h5555AAAA}) begin
      bad++; $display("[TB] FAIL cancel_last_hilo: got %h want aaaa55555555aaaa", {hi, lo});
    end
  endtask

  task automatic test_reset_mid_divide();
    issue(3'd2, 32'd1000, 32'd7);
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_busy: got %b want 0", busy); end
    total++; if ({hi, lo} !== 64'd0) begin bad++; $display("[TB] FAIL rst_mid_hilo: got %h want 0", {hi, lo}); end
    repeat (12) tick();
    total++; if ({busy, hi, lo} !== 65'd0) begin bad++; $display("[TB] FAIL rst_mid_later: got %h want 0", {busy, hi, lo}); end
  endtask

  task automatic test_random();
    int          n, want_n;
    logic [2:0]  r_op;
    logic [31:0] x, y, exp_hi, exp_lo;
    issue(3'd4, 32'd0, 32'd0);
    issue(3'd5, 32'd0, 32'd0);
    exp_hi = '0;
    exp_lo = '0;
    for (int i = 0; i < 60; i++) begin
      r_op = 3'($urandom_range(0, 7));
      x    = $urandom;
      y    = $urandom;
      if ($urandom_range(0, 7) == 0) y = 32'd0;
      if ($urandom_range(0, 9) == 0) begin x = 32'h80000000; y = 32'hFFFFFFFF; end
      if (r_op <= 3'd3) begin
        want_n = r_op[1] ? 10 : 5;
        {exp_hi, exp_lo} = model(r_op, x, y);
        issue(r_op, x, y);
        wait_idle(n);
        total++; if (n != want_n) begin bad++; $display("[TB] FAIL rand_cycles op=%0d: got %0d want %0d", r_op, n, want_n); end
      end else begin
        if (r_op == 3'd4) exp_hi = x;
        if (r_op == 3'd5) exp_lo = x;
        issue(r_op, x, y);
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rand_busy op=%0d: got %b want 0", r_op, busy); end
      end
      total++; if ({hi, lo} !== {exp_hi, exp_lo}) begin
        bad++; $display("[TB] FAIL rand_hilo op=%0d a=%h b=%h: got %h want %h", r_op, x, y, {hi, lo}, {exp_hi, exp_lo});
      end
    end
  endtask

  task automatic test_back_to_back();
    int          n;
    logic [63:0] exp;
    exp = model(3'd0, 32'hFFFF0003, 32'h00012345);
    issue(3'd0, 32'hFFFF0003, 32'h00012345);
    total++; if (busy1 !== 1'b1) begin bad++; $display("[TB] FAIL fast_busy_on: got %b want 1", busy1); end
    tick();
    total++; if (busy1 !== 1'b0) begin bad++; $display("[TB] FAIL fast_busy_off: got %b want 0", busy1); end
    total++; if ({hi1, lo1} !== exp) begin bad++; $display("[TB] FAIL fast_mult: got %h want %h", {hi1, lo1}, exp); end
    exp = model(3'd3, 32'd100, 32'd7);
    issue(3'd3, 32'd100, 32'd7);
    total++; if (busy1 !== 1'b1) begin bad++; $display("[TB] FAIL fast_b2b_busy: got %b want 1", busy1); end
    tick();
    total++; if (busy1 !== 1'b0) begin bad++; $display("[TB] FAIL fast_b2b_off: got %b want 0", busy1); end
    total++; if ({hi1, lo1} !== exp) begin bad++; $display("[TB] FAIL fast_divu: got %h want %h", {hi1, lo1}, exp); end
    wait_idle(n);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_move();
    test_start_while_busy();
    test_cancel();
    test_cancel_on_completion();
    test_reset_mid_divide();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
